// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter: captures a word on load/ready and shifts it
// out one bit per clock with valid, frame-start and end-of-word done strobes.
module piso_shift_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] parallel_in,
  output logic             ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_start,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             ready_reg, ready_next;
  logic             out_reg, out_next;
  logic             valid_reg, valid_next;
  logic             frame_reg, frame_next;
  logic             done_reg, done_next;

  logic accept;
  logic last_bit;

  assign accept   = load && ready_reg;
  assign last_bit = (state_reg == SHIFT) && (count_reg == LAST);

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      count_reg <= '0;
      ready_reg <= 1'b1;
      out_reg   <= 1'b0;
      valid_reg <= 1'b0;
      frame_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      count_reg <= count_next;
      ready_reg <= ready_next;
      out_reg   <= out_next;
      valid_reg <= valid_next;
      frame_reg <= frame_next;
      done_reg  <= done_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = SHIFT;
      SHIFT:   if (last_bit && !accept) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    shift_next = shift_reg;
    count_next = count_reg;
    ready_next = ready_reg;
    out_next   = out_reg;
    valid_next = valid_reg;
    frame_next = 1'b0;
    done_next  = 1'b0;
    if (accept) begin
      // Accept in SHIFT can only happen on the last-bit cycle: back-to-back word.
      shift_next = MSB_FIRST ? (parallel_in << 1) : (parallel_in >> 1);
      out_next   = MSB_FIRST ? parallel_in[WIDTH-1] : parallel_in[0];
      count_next = '0;
      valid_next = 1'b1;
      frame_next = 1'b1;
      ready_next = (WIDTH == 1);
      done_next  = (state_reg == SHIFT);
    end else if (state_reg == SHIFT) begin
      if (last_bit) begin
        count_next = '0;
        out_next   = 1'b0;
        valid_next = 1'b0;
        ready_next = 1'b1;
        done_next  = 1'b1;
      end else begin
        count_next = count_reg + CW'(1);
        shift_next = MSB_FIRST ? (shift_reg << 1) : (shift_reg >> 1);
        out_next   = MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0];
        valid_next = 1'b1;
        ready_next = ((count_reg + CW'(1)) == LAST);
      end
    end else begin
      out_next   = 1'b0;
      valid_next = 1'b0;
      ready_next = 1'b1;
    end
  end

  always_comb begin
    ready        = ready_reg;
    serial_out   = out_reg;
    serial_valid = valid_reg;
    frame_start  = frame_reg;
    done         = done_reg;
  end

endmodule
